// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE=0, LOCKED=1).
package fifo_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Scans requesters starting at the index just after last_grant and wrapping
// modulo NUM_REQ; the first set bit wins.
// Ports:
//   req        in  NUM_REQ          request vector
//   last_grant in  clog2(NUM_REQ)   index granted most recently
//   any        out 1                at least one request is set
//   winner     out clog2(NUM_REQ)   winning index (0 when any is low)
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int IDW = $clog2(NUM_REQ);

  logic found;

  always_comb begin
    any    = |req;
    winner = '0;
    found  = 1'b0;
    // Offsets 1..NUM_REQ: last_grant itself is checked last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      int idx;
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        winner = IDW'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter in front of a synchronous FIFO write port.
// A requester is locked from its first beat until its last beat transfers, so
// packets are never interleaved. Arbitration takes one IDLE cycle.
//
// Handshake: a beat on requester i transfers in the cycle where
// req_valid[i] && req_ready[i]; requesters hold valid/last/data stable until
// that cycle. req_ready only rises for the locked requester and only when the
// FIFO is not full, and fifo_wr_en is exactly that transfer.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_valid    per-requester beat valid
//   req_last     per-requester last beat of packet (qualified by req_valid)
//   req_data     requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    per-requester beat accept
//   fifo_full    downstream FIFO full flag
//   fifo_wr_en   FIFO write strobe
//   fifo_din     FIFO write data
//   grant_id     index of the locked requester (held while idle)
//   busy         high while LOCKED (FSM state observation)
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);

  arb_state_e     state, state_nxt;
  logic [IDW-1:0] grant_nxt;
  logic [IDW-1:0] last_grant, last_nxt;
  logic           pick_any;
  logic [IDW-1:0] pick_winner;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .any        (pick_any),
    .winner     (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      // Starting from the top index makes requester 0 the first winner.
      last_grant <= IDW'(NUM_REQ - 1);
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_id;
    last_nxt   = last_grant;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    // Data path is a plain mux; only meaningful when fifo_wr_en is high.
    fifo_din   = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_winner;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        // Gated by rst so nothing transfers while reset is being applied.
        req_ready[grant_id] = !fifo_full && !rst;
        fifo_wr_en          = req_valid[grant_id] && !fifo_full && !rst;
        if (fifo_wr_en && req_last[grant_id]) begin
          state_nxt = IDLE;
          last_nxt  = grant_id;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester beat drivers feed stimulus queues,
// every presented beat is pushed into that requester's expected queue, and a
// negedge monitor runs a packet-level round-robin reference to decide which
// queue the next FIFO write must come from.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int IDW = $clog2(N);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [IDW-1:0]  grant_id;
  logic            busy;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  // ---------------- scoreboard state ----------------
  int compared   = 0;
  int mismatched = 0;

  logic [DW:0]   stim_q[N][$];  // {last, data} still to be presented
  logic [DW-1:0] exp_q[N][$];   // beats presented, awaiting FIFO write
  logic [N-1:0]  presenting = '0;
  logic [N-1:0]  hold       = '0;
  int            bubble_pct = 0;
  int            full_pct   = 0;
  logic          force_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  // Packet-level view: when no packet is open and someone is valid, the next
  // packet owner is the first valid index after the previous owner; the
  // owner's beats then go out whenever it is valid and the FIFO has room.
  int   m_locked = 0;
  int   m_gid    = 0;
  int   m_last   = N - 1;

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    logic         exp_wr;
    logic [DW-1:0] exp_d;
    chk("one_hot_ready", 32'($countones(req_ready) <= 1), 32'd1);
    chk("no_wr_when_full", 32'(fifo_wr_en && fifo_full), 32'd0);
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      m_locked = 0;
      m_gid    = 0;
      m_last   = N - 1;
    end else begin
      exp_ready = '0;
      if (m_locked != 0 && !fifo_full) exp_ready[m_gid] = 1'b1;
      exp_wr = (m_locked != 0) && req_valid[m_gid] && !fifo_full;
      chk("busy", 32'(busy), 32'(m_locked));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
      if (exp_wr) begin
        if (exp_q[m_gid].size() == 0) begin
          chk("exp_q_empty", 32'd1, 32'd0);
        end else begin
          exp_d = exp_q[m_gid].pop_front();
          chk("fifo_din", 32'(fifo_din), 32'(exp_d));
        end
      end
      if (m_locked != 0) begin
        if (exp_wr && req_last[m_gid]) begin
          m_locked = 0;
          m_last   = m_gid;
        end
      end else if (|req_valid) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (m_locked == 0 && req_valid[idx]) begin
            m_gid    = idx;
            m_locked = 1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [N-1:0] acc;
    logic [DW:0]  b;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        void'(stim_q[i].pop_front());
        presenting[i] = 1'b0;
        req_valid[i]  = 1'b0;
      end
      if (!presenting[i] && !hold[i] && stim_q[i].size() > 0 &&
          $urandom_range(0, 99) >= bubble_pct) begin
        b = stim_q[i][0];
        req_valid[i]          = 1'b1;
        req_last[i]           = b[DW];
        req_data[i*DW +: DW]  = b[DW-1:0];
        exp_q[i].push_back(b[DW-1:0]);
        presenting[i]         = 1'b1;
      end
    end
    fifo_full = force_full || (int'($urandom_range(0, 99)) < full_pct);
  endtask

  task automatic push_pkt(input int r, input int len, input logic [DW-1:0] base, input bit rnd);
    for (int k = 0; k < len; k++) begin
      logic [DW-1:0] d;
      d = rnd ? DW'($urandom_range(0, 255)) : base + DW'(k);
      stim_q[r].push_back({(k == len - 1), d});
    end
  endtask

  function automatic bit all_sent();
    for (int i = 0; i < N; i++) if (stim_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    int n = 0;
    while ((!all_sent() || busy) && n < 3000) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < 3000), 32'd1);
  endtask

  task automatic step_until_left(input int r, input int left);
    int n = 0;
    while (stim_q[r].size() != left && n < 200) begin
      step();
      n++;
    end
    chk("wait_timeout", 32'(n < 200), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Single 3-beat packet on requester 0.
    push_pkt(0, 3, 8'hA1, 1'b0);
    drain();

    // All requesters continuously valid with single-beat packets.
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < N; i++) push_pkt(i, 1, DW'((i + 1) * 16), 1'b0);
    drain();

    // Requester 2 stalled mid-packet by a full FIFO for 5 cycles.
    push_pkt(2, 4, 8'h50, 1'b0);
    step_until_left(2, 3);
    force_full = 1'b1;
    fifo_full  = 1'b1;
    repeat (5) step();
    force_full = 1'b0;
    drain();

    // Requester 1 bubbles for 3 cycles while requester 3 waits.
    hold[1] = 1'b1;
    push_pkt(1, 3, 8'h60, 1'b0);
    hold[1] = 1'b0;
    step_until_left(1, 2);
    hold[1] = 1'b1;
    step();
    push_pkt(3, 1, 8'h70, 1'b0);
    repeat (3) step();
    hold[1] = 1'b0;
    drain();

    // Reset on the 2nd beat of a 4-beat packet.
    push_pkt(2, 4, 8'h80, 1'b0);
    step_until_left(2, 3);
    rst = 1'b1;
    step();
    for (int i = 0; i < N; i++) begin
      stim_q[i].delete();
      exp_q[i].delete();
    end
    presenting = '0;
    req_valid  = '0;
    rst        = 1'b0;
    push_pkt(2, 1, 8'h92, 1'b0);
    push_pkt(0, 1, 8'h90, 1'b0);
    drain();

    // Randomized traffic with bubbles and FIFO back-pressure.
    bubble_pct = 20;
    full_pct   = 25;
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < N; i++)
        for (int p = 0; p < 5; p++)
          push_pkt(i, int'($urandom_range(1, 4)), '0, 1'b1);
      drain();
    end
    full_pct = 0;
    repeat (3) step();

    for (int i = 0; i < N; i++)
      chk("leftover_beats", 32'(exp_q[i].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
